// File: rtl/uart_link_controller.sv
// uart_link_controller
//   Shares one Uart transmitter between REQUESTERS byte producers using
//   round-robin arbitration. Received bytes are forwarded to one consumer
//   over valid/ready. The Uart's level handshakes (write_i/write_busy_o and
//   read_ready_o/ack_i) are turned into plain valid/ready ports.
// Ports:
//   clock_i, reset_i           clock, synchronous active-high reset
//   req_valid_i/req_data_i     per-requester byte offers (byte k in [8k+7:8k])
//   req_ready_o                one-hot grant, combinational, TX_IDLE only
//   owner_o                    index of the most recently granted requester
//   uart_write_o/uart_data_o   to Uart write_i/data_i
//   uart_write_busy_i          from Uart write_busy_o
//   uart_read_ready_i/uart_data_i  from Uart read_ready_o/data_o
//   uart_ack_o                 to Uart ack_i
//   rx_valid_o/rx_data_o/rx_ready_i  received-byte stream to the consumer
module uart_link_controller #(
  parameter int unsigned REQUESTERS = 4
) (
  input  logic                            clock_i,
  input  logic                            reset_i,
  input  logic [REQUESTERS-1:0]           req_valid_i,
  input  logic [8*REQUESTERS-1:0]         req_data_i,
  output logic [REQUESTERS-1:0]           req_ready_o,
  output logic [$clog2(REQUESTERS)-1:0]   owner_o,
  output logic                            uart_write_o,
  output logic [7:0]                      uart_data_o,
  input  logic                            uart_write_busy_i,
  input  logic                            uart_read_ready_i,
  input  logic [7:0]                      uart_data_i,
  output logic                            uart_ack_o,
  output logic                            rx_valid_o,
  output logic [7:0]                      rx_data_o,
  input  logic                            rx_ready_i
);

  localparam int unsigned PW = $clog2(REQUESTERS);

  typedef enum logic [1:0] {TX_IDLE, TX_WRITE, TX_DRAIN} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_HOLD}    rx_state_t;

  // ---------------- TX path ----------------
  tx_state_t                        r_tx_state;
  tx_state_t                        w_tx_next;
  logic [PW-1:0]                    r_ptr;
  logic [PW-1:0]                    r_owner;
  logic [7:0]                       r_tx_data;
  logic                             w_win_found;
  logic [PW-1:0]                    w_win_idx;
  logic [PW-1:0]                    w_cand;
  logic                             w_grant;
  logic [REQUESTERS-1:0][7:0]       w_req_bytes;

  assign w_req_bytes = req_data_i;

  // Search pointer+1, pointer+2, ... (mod REQUESTERS); first valid wins.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_cand      = '0;
    for (int unsigned step = 1; step <= REQUESTERS; step++) begin
      w_cand = PW'((32'(r_ptr) + step) % REQUESTERS);
      if (!w_win_found && req_valid_i[w_cand]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_cand;
      end
    end
  end

  assign w_grant = (r_tx_state == TX_IDLE) && !uart_write_busy_i && w_win_found;

  always_comb begin
    req_ready_o = '0;
    if (w_grant) begin
      req_ready_o[w_win_idx] = 1'b1;
    end
  end

  always_comb begin
    w_tx_next = r_tx_state;
    unique case (r_tx_state)
      TX_IDLE:  if (w_grant)            w_tx_next = TX_WRITE;
      TX_WRITE: if (uart_write_busy_i)  w_tx_next = TX_DRAIN;
      TX_DRAIN: if (!uart_write_busy_i) w_tx_next = TX_IDLE;
      default:                          w_tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_tx_state <= TX_IDLE;
      r_ptr      <= PW'(REQUESTERS - 1);
      r_owner    <= '0;
      r_tx_data  <= '0;
    end else begin
      r_tx_state <= w_tx_next;
      if (w_grant) begin
        r_tx_data <= w_req_bytes[w_win_idx];
        r_owner   <= w_win_idx;
        r_ptr     <= w_win_idx;
      end
    end
  end

  assign uart_write_o = (r_tx_state == TX_WRITE);
  assign uart_data_o  = r_tx_data;
  assign owner_o      = r_owner;

  // ---------------- RX path ----------------
  rx_state_t   r_rx_state;
  rx_state_t   w_rx_next;
  logic        r_rx_valid;
  logic [7:0]  r_rx_data;
  logic        r_ack;
  logic        w_rx_valid_nxt;
  logic [7:0]  w_rx_data_nxt;
  logic        w_ack_nxt;
  logic        w_consume;

  assign w_consume = r_rx_valid && rx_ready_i;

  // The consumer handshake clears rx_valid in every state; capture only
  // happens in RX_IDLE with the holding register empty, so they never collide.
  always_comb begin
    w_rx_next      = r_rx_state;
    w_rx_valid_nxt = w_consume ? 1'b0 : r_rx_valid;
    w_rx_data_nxt  = r_rx_data;
    w_ack_nxt      = r_ack;
    unique case (r_rx_state)
      RX_IDLE: begin
        if (uart_read_ready_i && !r_rx_valid) begin
          w_rx_data_nxt  = uart_data_i;
          w_rx_valid_nxt = 1'b1;
          w_ack_nxt      = 1'b1;
          w_rx_next      = RX_ACK;
        end
      end
      RX_ACK: begin
        if (!uart_read_ready_i) begin
          w_ack_nxt = 1'b0;
          w_rx_next = RX_HOLD;
        end
      end
      RX_HOLD: begin
        if (!r_rx_valid || w_consume) begin
          w_rx_next = RX_IDLE;
        end
      end
      default: w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_rx_state <= RX_IDLE;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_ack      <= 1'b0;
    end else begin
      r_rx_state <= w_rx_next;
      r_rx_valid <= w_rx_valid_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_ack      <= w_ack_nxt;
    end
  end

  assign rx_valid_o = r_rx_valid;
  assign rx_data_o  = r_rx_data;
  assign uart_ack_o = r_ack;

endmodule

// File: tb/tb_uart_link_controller.sv
`timescale 1ns/1ps
module tb_uart_link_controller;

  localparam int N     = 4;
  localparam int NB    = 8;
  localparam int FRAME = 2;

  logic             clock_i = 1'b0;
  logic             reset_i = 1'b1;
  logic [N-1:0]     req_valid_i = '0;
  logic [8*N-1:0]   req_data_i = '0;
  logic [N-1:0]     req_ready_o;
  logic [1:0]       owner_o;
  logic             uart_write_o;
  logic [7:0]       uart_data_o;
  logic             uart_write_busy_i;
  logic             uart_read_ready_i;
  logic [7:0]       uart_data_i;
  logic             uart_ack_o;
  logic             rx_valid_o;
  logic [7:0]       rx_data_o;
  logic             rx_ready_i = 1'b0;

  // manual drive vs. Uart loopback model
  logic       model_en = 1'b0;
  logic       man_busy = 1'b0;
  logic       man_rr   = 1'b0;
  logic [7:0] man_rdata = '0;
  logic       m_busy, m_rx_full;
  logic [7:0] m_byte, m_rx_byte;
  int         m_cnt;
  logic [7:0] line_q[$];
  logic [7:0] lat_q[$];

  assign uart_write_busy_i = model_en ? m_busy    : man_busy;
  assign uart_read_ready_i = model_en ? m_rx_full : man_rr;
  assign uart_data_i       = model_en ? m_rx_byte : man_rdata;

  int total = 0;
  int bad   = 0;

  uart_link_controller #(.REQUESTERS(N)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .owner_o(owner_o), .uart_write_o(uart_write_o), .uart_data_o(uart_data_o),
    .uart_write_busy_i(uart_write_busy_i), .uart_read_ready_i(uart_read_ready_i),
    .uart_data_i(uart_data_i), .uart_ack_o(uart_ack_o),
    .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o), .rx_ready_i(rx_ready_i)
  );

  always #5 clock_i = ~clock_i;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Uart behaviour: latch on write while idle, busy for FRAME+1 cycles, then
  // the byte appears on the loopback receive side; ack clears read_ready.
  always @(posedge clock_i) begin
    if (reset_i || !model_en) begin
      m_busy <= 1'b0; m_cnt <= 0; m_byte <= '0;
      m_rx_full <= 1'b0; m_rx_byte <= '0;
      line_q.delete(); lat_q.delete();
    end else begin
      if (m_busy) begin
        if (m_cnt == 0) begin
          m_busy <= 1'b0;
          line_q.push_back(m_byte);
        end else m_cnt <= m_cnt - 1;
      end else if (uart_write_o) begin
        m_busy <= 1'b1; m_cnt <= FRAME; m_byte <= uart_data_o;
        lat_q.push_back(uart_data_o);
      end
      if (m_rx_full && uart_ack_o) m_rx_full <= 1'b0;
      else if (!m_rx_full && !uart_ack_o && line_q.size() > 0) begin
        m_rx_full <= 1'b1;
        m_rx_byte <= line_q.pop_front();
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int s = 1; s <= N; s++) begin
      int k;
      k = (p + s) % N;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clock_i);
    reset_i = 1'b1; req_valid_i = '0; rx_ready_i = 1'b0;
    man_busy = 1'b0; man_rr = 1'b0;
    @(posedge clock_i); @(posedge clock_i);
    @(negedge clock_i);
    reset_i = 1'b0;
  endtask

  task automatic wait_accept(output int idx);
    logic done;
    idx = -1; done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clock_i); #1;
      if ((req_ready_o & req_valid_i) != '0) begin
        for (int k = 0; k < N; k++) if (req_ready_o[k]) idx = k;
        @(posedge clock_i); #1;
        done = 1'b1;
      end
    end
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic [31:0]  data;
    logic [N-1:0] exp_ready;
    logic [7:0]   exp_data;
    int           exp_owner;
  } vec_t;

  vec_t        tbl [11];
  logic [7:0]  src_mem [N][NB];
  int          src_pos [N];
  logic [N-1:0] vld;
  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];

  initial begin
    int idx, ptr;
    logic fin;
    tbl[0]  = '{4'b1111, 32'h13121110, 4'b0001, 8'h10, 0};
    tbl[1]  = '{4'b1111, 32'h13121110, 4'b0010, 8'h11, 1};
    tbl[2]  = '{4'b1111, 32'h13121110, 4'b0100, 8'h12, 2};
    tbl[3]  = '{4'b1111, 32'h13121110, 4'b1000, 8'h13, 3};
    tbl[4]  = '{4'b1111, 32'h13121110, 4'b0001, 8'h10, 0};
    tbl[5]  = '{4'b0101, 32'h13121110, 4'b0100, 8'h12, 2};
    tbl[6]  = '{4'b0011, 32'h13121110, 4'b0001, 8'h10, 0};
    tbl[7]  = '{4'b1010, 32'h13121110, 4'b0010, 8'h11, 1};
    tbl[8]  = '{4'b1010, 32'h13121110, 4'b1000, 8'h13, 3};
    tbl[9]  = '{4'b0000, 32'h13121110, 4'b0000, 8'h00, 3};
    tbl[10] = '{4'b0100, 32'h13A51110, 4'b0100, 8'hA5, 2};

    // ---- reset values ----
    do_reset();
    #1;
    check("rst_write", int'(uart_write_o), 0);
    check("rst_data",  int'(uart_data_o), 0);
    check("rst_ack",   int'(uart_ack_o), 0);
    check("rst_rxv",   int'(rx_valid_o), 0);
    check("rst_rxd",   int'(rx_data_o), 0);
    check("rst_owner", int'(owner_o), 0);
    check("rst_ready", int'(req_ready_o), 0);

    // ---- table-driven grant sequence (manual busy) ----
    foreach (tbl[i]) begin
      @(negedge clock_i);
      req_valid_i = tbl[i].valid; req_data_i = tbl[i].data; man_busy = 1'b0;
      #1;
      check("tbl_ready", int'(req_ready_o), int'(tbl[i].exp_ready));
      if (tbl[i].exp_ready != '0) begin
        @(posedge clock_i); #1; req_valid_i = '0;
        @(negedge clock_i);
        check("tbl_write", int'(uart_write_o), 1);
        check("tbl_data",  int'(uart_data_o), int'(tbl[i].exp_data));
        check("tbl_owner", int'(owner_o), tbl[i].exp_owner);
        man_busy = 1'b1; req_valid_i = 4'hF;
        @(posedge clock_i); @(negedge clock_i);
        check("tbl_wdrop", int'(uart_write_o), 0);
        check("tbl_busy_ready", int'(req_ready_o), 0);
        @(posedge clock_i); @(negedge clock_i);
        check("tbl_drain_ready", int'(req_ready_o), 0);
        check("tbl_hold_data", int'(uart_data_o), int'(tbl[i].exp_data));
        man_busy = 1'b0; req_valid_i = '0;
        @(posedge clock_i);
      end else begin
        @(posedge clock_i); @(negedge clock_i);
        check("tbl_owner_idle", int'(owner_o), tbl[i].exp_owner);
        check("tbl_write_idle", int'(uart_write_o), 0);
      end
    end

    // ---- RX with backpressure ----
    @(negedge clock_i);
    man_rr = 1'b1; man_rdata = 8'h3C; rx_ready_i = 1'b0;
    @(posedge clock_i); @(negedge clock_i);
    check("rx1_valid", int'(rx_valid_o), 1);
    check("rx1_data",  int'(rx_data_o), 8'h3C);
    check("rx1_ack",   int'(uart_ack_o), 1);
    @(posedge clock_i); @(negedge clock_i);
    check("rx1_ack_hold", int'(uart_ack_o), 1);
    man_rr = 1'b0;
    @(posedge clock_i); @(negedge clock_i);
    check("rx1_ack_drop", int'(uart_ack_o), 0);
    check("rx1_valid_hold", int'(rx_valid_o), 1);
    man_rr = 1'b1; man_rdata = 8'hC3;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock_i); @(negedge clock_i);
      check("rx_bp_ack", int'(uart_ack_o), 0);
      check("rx_bp_data", int'(rx_data_o), 8'h3C);
    end
    rx_ready_i = 1'b1;
    @(posedge clock_i); @(negedge clock_i);
    rx_ready_i = 1'b0;
    check("rx1_consumed", int'(rx_valid_o), 0);
    check("rx1_no_ack", int'(uart_ack_o), 0);
    @(posedge clock_i); @(negedge clock_i);
    check("rx2_valid", int'(rx_valid_o), 1);
    check("rx2_data",  int'(rx_data_o), 8'hC3);
    check("rx2_ack",   int'(uart_ack_o), 1);
    man_rr = 1'b0;
    @(posedge clock_i); @(negedge clock_i);
    check("rx2_ack_drop", int'(uart_ack_o), 0);
    rx_ready_i = 1'b1;
    @(posedge clock_i); @(negedge clock_i);
    rx_ready_i = 1'b0;
    check("rx2_consumed", int'(rx_valid_o), 0);

    // ---- reset mid-frame with a pending RX byte ----
    @(negedge clock_i);
    man_rr = 1'b1; man_rdata = 8'h77;
    @(posedge clock_i); @(negedge clock_i);
    man_rr = 1'b0;
    check("mid_rx_pending", int'(rx_valid_o), 1);
    req_valid_i = 4'b0001; req_data_i = 32'h13121155;
    @(posedge clock_i); #1; req_valid_i = '0;
    @(negedge clock_i);
    check("mid_write", int'(uart_write_o), 1);
    man_busy = 1'b1; reset_i = 1'b1;
    @(posedge clock_i); @(negedge clock_i);
    reset_i = 1'b0; req_valid_i = 4'hF; req_data_i = 32'h13121110;
    #1;
    check("mid_write", int'(uart_write_o), 0);
    check("mid_data",  int'(uart_data_o), 0);
    check("mid_ack",   int'(uart_ack_o), 0);
    check("mid_rxv",   int'(rx_valid_o), 0);
    check("mid_rxd",   int'(rx_data_o), 0);
    check("mid_owner", int'(owner_o), 0);
    check("mid_ready", int'(req_ready_o), 0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clock_i); @(negedge clock_i);
      check("mid_busy_nogrant", int'(req_ready_o), 0);
    end
    man_busy = 1'b0; #1;
    check("mid_first_grant", int'(req_ready_o), 4'b0001);
    @(posedge clock_i); #1; req_valid_i = '0;
    @(negedge clock_i);
    check("mid_first_data", int'(uart_data_o), 8'h10);
    man_busy = 1'b1;
    @(posedge clock_i); @(negedge clock_i);
    man_busy = 1'b0;
    @(posedge clock_i);

    // ---- fairness: 1 continuous, 3 once after grant to 1 ----
    do_reset();
    model_en = 1'b1; rx_ready_i = 1'b1;
    req_data_i = 32'h23002100; req_valid_i = 4'b0010;
    wait_accept(idx); check("starve_g0", idx, 1);
    req_valid_i[3] = 1'b1;
    wait_accept(idx); check("starve_g1", idx, 3);
    req_valid_i[3] = 1'b0;
    wait_accept(idx); check("starve_g2", idx, 1);
    req_valid_i = '0;

    // ---- randomized loopback against the arbitration/ordering model ----
    do_reset();
    model_en = 1'b1;
    for (int r = 0; r < N; r++) begin
      src_pos[r] = 0;
      for (int n = 0; n < NB; n++) src_mem[r][n] = 8'($urandom_range(0, 255));
    end
    src_mem[0][0] = 8'h00; src_mem[3][0] = 8'hFF; src_mem[1][NB-1] = 8'hFF;
    vld = '0; ptr = N - 1; fin = 1'b0;
    txq.delete(); rxq.delete();
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      @(negedge clock_i);
      for (int r = 0; r < N; r++) begin
        if (src_pos[r] < NB) begin
          if (!vld[r] && $urandom_range(0, 2) != 0) vld[r] = 1'b1;
          req_data_i[8*r +: 8] = src_mem[r][src_pos[r]];
        end else begin
          vld[r] = 1'b0;
          req_data_i[8*r +: 8] = '0;
        end
      end
      req_valid_i = vld;
      rx_ready_i = ($urandom_range(0, 3) != 0);
      #1;
      while (lat_q.size() > 0) begin
        if (txq.size() == 0) begin
          check("lb_spurious_tx", int'(lat_q.pop_front()), -1);
        end else check("lb_tx_byte", int'(lat_q.pop_front()), int'(txq.pop_front()));
      end
      if (req_ready_o != '0) begin
        idx = rr_pick(vld, ptr);
        check("lb_rr", int'(req_ready_o), (idx < 0) ? 0 : (1 << idx));
        check("lb_grant_busy", int'(uart_write_busy_i), 0);
        if (idx >= 0) begin
          txq.push_back(src_mem[idx][src_pos[idx]]);
          rxq.push_back(src_mem[idx][src_pos[idx]]);
          src_pos[idx]++;
          vld[idx] = 1'b0;
          ptr = idx;
        end
      end
      if (rx_valid_o && rx_ready_i) begin
        if (rxq.size() == 0) check("lb_spurious_rx", int'(rx_data_o), -1);
        else check("lb_rx_byte", int'(rx_data_o), int'(rxq.pop_front()));
      end
      fin = 1'b1;
      for (int r = 0; r < N; r++) if (src_pos[r] < NB) fin = 1'b0;
      if (rxq.size() != 0 || rx_valid_o) fin = 1'b0;
      @(posedge clock_i);
    end
    check("lb_all_delivered", int'(fin), 1);
    req_valid_i = '0; rx_ready_i = 1'b0; model_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_link_controller.md
# uart_link_controller

Controller that shares one `Uart` transmitter between `REQUESTERS` byte producers using round-robin arbitration. It also forwards received bytes to a single consumer over a valid/ready interface. It sequences the Uart's level-sensitive `write_i`/`write_busy_o` and `read_ready_o`/`ack_i` handshakes so that producers and the consumer see plain valid/ready ports. It sits between application logic and one `Uart` instance and runs in the same clock domain.

## Interface
- `REQUESTERS`, 4: number of transmit requesters, ≥ 2.
- `clock_i`  in  1: system clock, all logic on rising edge.
- `reset_i`  in  1: synchronous, active-high reset.
- `req_valid_i`  in  REQUESTERS: requester k has a byte to send.
- `req_data_i`  in  8·REQUESTERS: byte k in bits [8k+7:8k].
- `req_ready_o`  out  REQUESTERS: one-hot, combinational; byte k is accepted on the edge where valid[k] and ready[k] are both high.
- `owner_o`  out  clog2(REQUESTERS): index of the requester that was granted last.
- `uart_write_o`  out  1: drives Uart `write_i`.
- `uart_data_o`  out  8: drives Uart `data_i`.
- `uart_write_busy_i`  in  1: from Uart `write_busy_o`.
- `uart_read_ready_i`  in  1: from Uart `read_ready_o`.
- `uart_data_i`  in  8: from Uart `data_o`.
- `uart_ack_o`  out  1: drives Uart `ack_i`.
- `rx_valid_o`  out  1: received byte available.
- `rx_data_o`  out  8: received byte.
- `rx_ready_i`  in  1: consumer accepts the byte on an edge where it and `rx_valid_o` are both high.

## Operation
- Uart contract:
  - The Uart latches `data_i` while `write_i` is high and it is not busy.
  - It then raises `write_busy_o` until the frame is complete.
  - `ack_i` high clears `read_ready_o`.
- TX state machine has three states: TX_IDLE, TX_WRITE, TX_DRAIN.
  - **TX_IDLE**: If any `req_valid_i` is high and `uart_write_busy_i` is 0, grant winner w.
    - `req_ready_o[w]` = 1 this cycle.
    - On the edge: latch the byte into `uart_data_o`, set `owner_o` = w, set pointer = w, go to TX_WRITE.
    - If `uart_write_busy_i` is 1, no grant is issued.
  - **TX_WRITE**: `uart_write_o` = 1 and `uart_data_o` is held. When `uart_write_busy_i` is sampled 1, go to TX_DRAIN.
  - **TX_DRAIN**: `uart_write_o` = 0. When `uart_write_busy_i` is sampled 0, go to TX_IDLE.
- Round-robin:
  - Search order is pointer+1, pointer+2, … mod REQUESTERS.
  - Pointer resets to REQUESTERS−1, so requester 0 has first priority.
  - `req_ready_o` is all-zero outside TX_IDLE.
- RX state machine has three states: RX_IDLE, RX_ACK, RX_HOLD.
  - **RX_IDLE**: If `uart_read_ready_i` is 1 and `rx_valid_o` is 0, then on the edge: `rx_data_o` ← `uart_data_i`, `rx_valid_o` ← 1, `uart_ack_o` ← 1, go to RX_ACK.
  - **RX_ACK**: `uart_ack_o` stays 1 until `uart_read_ready_i` is sampled 0. Then `uart_ack_o` ← 0 and go to RX_HOLD.
  - **RX_HOLD**: Go to RX_IDLE on the first edge where `rx_valid_o` is 0, or on the same edge that clears it.
  - `rx_valid_o` clears on a valid/ready edge in any RX state. `uart_ack_o` is unaffected by that.
- Backpressure: while `rx_valid_o` = 1, no new capture and no ack. The byte stays in the Uart.
- TX and RX are independent. Simultaneous activity in both is legal.

## Timing
- Reset values: `uart_write_o` 0, `uart_data_o` 0x00, `uart_ack_o` 0, `rx_valid_o` 0, `rx_data_o` 0x00, `owner_o` 0, `req_ready_o` 0. States reset to TX_IDLE and RX_IDLE; pointer resets to REQUESTERS−1.
- Grant in cycle t (TX_IDLE) → `uart_write_o` = 1 from t+1.
- Busy sampled high in cycle b → `uart_write_o` = 0 from b+1.
- Earliest next grant is the first cycle after busy is sampled low.
- RX capture at edge c → `rx_valid_o` and `uart_ack_o` high from c+1.
- Reset mid-frame: `uart_write_o` drops the cycle after reset. No grant is issued while the Uart still reports busy. A pending `rx_data_o` is discarded.
- `req_valid_i` deasserting while not granted has no effect. A requester must hold valid and data until ready.

## Test plan
- Single request: requester 2 sends 0xA5 from reset.
  - Expected: `req_ready_o` = 4'b0100 in the same cycle.
  - `uart_write_o` = 1 with `uart_data_o` = 0xA5 the next cycle.
  - Write drops one cycle after the model raises busy.
- All four valid, holding bytes 0x10–0x13.
  - Expected grant order is 0, 1, 2, 3, 0 and `uart_data_o` follows.
  - No grant while busy = 1.
- Requester 1 requests continuously while 3 requests once after the grant to 1.
  - Expected order: 1, 3, 1. Requester 3 is not starved.
- RX byte 0x3C with `rx_ready_i` = 0 for 10 cycles.
  - Expected: `rx_valid_o` = 1 and `uart_ack_o` pulses until read_ready falls.
  - A second read_ready during hold is not acked until the consumer accepts.
  - Then 0x3C is delivered followed by the second byte.
- Reset asserted while in TX_WRITE with model busy = 1.
  - Expected: all outputs at reset values.
  - No grant until busy falls.
  - Requester 0 is granted first afterward.
- TX and RX active together: a loopback model echoes bytes; bytes 0x00 and 0xFF round-trip unchanged.
